// File: rtl/ccff_loader.sv
// Configuration-chain loader: optional flush/probe of the scan chain length,
// then streams a word-wide bitstream into the chain MSB-first.
module ccff_loader #(
  parameter int BS_LGT   = 8387,
  parameter int WORD_W   = 32,
  parameter int PROBE_EN = 1
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int NWORDS    = (BS_LGT + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = BS_LGT - (NWORDS - 1) * WORD_W;
  localparam int CNT_W     = $clog2(BS_LGT + 9);
  localparam int SB_W      = $clog2(WORD_W + 1);
  localparam int WC_W      = $clog2(NWORDS + 1);

  localparam logic [CNT_W-1:0] C_LGT  = CNT_W'(BS_LGT);
  localparam logic [CNT_W-1:0] C_TMO  = CNT_W'(BS_LGT + 8);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [SB_W-1:0]  SB_FULL = SB_W'(WORD_W);
  localparam logic [SB_W-1:0]  SB_LAST = SB_W'(LAST_BITS);
  localparam logic [SB_W-1:0]  SB_ONE  = SB_W'(1);
  localparam logic [WC_W-1:0]  WC_ALL  = WC_W'(NWORDS);
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(NWORDS - 1);
  localparam logic [WC_W-1:0]  WC_ONE  = WC_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_PROBE, S_LOAD, S_DONE, S_ERROR
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [WC_W-1:0]   r_words;
  logic [SB_W-1:0]   r_sbits;
  logic [WORD_W-1:0] r_sreg;
  logic              r_head;
  logic              r_en;
  logic              r_done;
  logic              r_error;
  logic [1:0]        r_err_code;

  logic            w_sb_empty;
  logic            w_accept;
  logic            w_bit_avail;
  logic            w_bit;
  logic [SB_W-1:0] w_word_bits;

  assign w_sb_empty  = (r_sbits == '0);
  assign bs_ready    = (r_state == S_LOAD) && (r_cnt != C_LGT) && (r_words != WC_ALL) &&
                       (w_sb_empty || (r_sbits == SB_ONE));
  assign w_accept    = bs_valid && bs_ready;
  assign w_bit_avail = !w_sb_empty || w_accept;
  // An empty register takes its bit straight from the incoming word so there is no refill bubble.
  assign w_bit       = w_sb_empty ? bs_data[WORD_W-1] : r_sreg[WORD_W-1];
  // Only the top bits of the final word belong to the chain.
  assign w_word_bits = (r_words == WC_LAST) ? SB_LAST : SB_FULL;

  assign busy        = (r_state == S_FLUSH) || (r_state == S_PROBE) || (r_state == S_LOAD);
  assign ccff_head   = r_head;
  assign prog_clk_en = r_en;
  assign done        = r_done;
  assign error       = r_error;
  assign err_code    = r_err_code;

  always_ff @(posedge prog_clk) begin
    if (pReset || abort) begin
      r_state    <= S_IDLE;
      r_head     <= 1'b0;
      r_en       <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= 2'b00;
      r_cnt      <= '0;
      r_words    <= '0;
      r_sbits    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          r_en <= 1'b0;
          if (start) begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 2'b00;
            r_cnt      <= '0;
            r_words    <= '0;
            r_sbits    <= '0;
            r_head     <= 1'b0;
            if (PROBE_EN != 0) begin
              r_state <= S_FLUSH;
              r_en    <= 1'b1;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_FLUSH: begin
          r_en   <= 1'b1;
          r_head <= 1'b0;
          if (r_cnt == C_LGT - C_ONE) begin
            r_state <= S_PROBE;
            r_cnt   <= '0;
            r_head  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_PROBE: begin
          // The single 1 injected at count 0 reaches the tail after exactly BS_LGT shifts.
          r_en   <= 1'b1;
          r_head <= 1'b0;
          if (ccff_tail && (r_cnt != '0) && (r_cnt <= C_LGT)) begin
            r_en <= 1'b0;
            if (r_cnt == C_LGT) begin
              r_state <= S_LOAD;
              r_cnt   <= '0;
            end else begin
              r_state    <= S_ERROR;
              r_error    <= 1'b1;
              r_err_code <= 2'b01;
            end
          end else if (r_cnt == C_TMO) begin
            r_state    <= S_ERROR;
            r_error    <= 1'b1;
            r_err_code <= 2'b10;
            r_en       <= 1'b0;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_LOAD: begin
          if (r_cnt == C_LGT) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_en    <= 1'b0;
          end else if (w_bit_avail) begin
            r_en   <= 1'b1;
            r_head <= w_bit;
            r_cnt  <= r_cnt + C_ONE;
            if (w_accept) begin
              r_words <= r_words + WC_ONE;
              r_sbits <= w_sb_empty ? (w_word_bits - SB_ONE) : w_word_bits;
            end else begin
              r_sbits <= r_sbits - SB_ONE;
            end
          end else begin
            r_en <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Word shift register carries data only, so it is left out of reset.
  always_ff @(posedge prog_clk) begin
    if ((r_state == S_LOAD) && (r_cnt != C_LGT)) begin
      if (w_accept) begin
        r_sreg <= w_sb_empty ? {bs_data[WORD_W-2:0], 1'b0} : bs_data;
      end else if (!w_sb_empty) begin
        r_sreg <= {r_sreg[WORD_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader with a 40-bit chain model (37-bit and stuck-0 variants)
// and a bit-level scoreboard on ccff_head during LOAD.
module tb_ccff_loader;

  localparam int BS = 40;
  localparam int WW = 16;

  logic          prog_clk = 1'b0;
  logic          pReset, start, abort, bs_valid;
  logic [WW-1:0] bs_data;
  logic          bs_ready, ccff_head, ccff_tail, prog_clk_en, busy, done, error;
  logic [1:0]    err_code;

  ccff_loader #(.BS_LGT(BS), .WORD_W(WW), .PROBE_EN(1)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .prog_clk_en(prog_clk_en),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: mode 0 = 40-bit, 1 = 37-bit, 2 = tail stuck at 0.
  logic [BS-1:0] chain = '0;
  int            tail_mode = 0;
  always @(posedge prog_clk) if (prog_clk_en) chain <= {chain[BS-2:0], ccff_head};
  assign ccff_tail = (tail_mode == 0) ? chain[BS-1] : (tail_mode == 1) ? chain[36] : 1'b0;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic       sb[$];
  int         phase, n_flush, n_probe, n_load, n_bubble;
  logic       ready_seen, off_err;

  always @(negedge prog_clk) begin
    if (bs_ready) ready_seen = 1'b1;
    case (phase)
      0: if (prog_clk_en) begin
           if (ccff_head) begin phase = 1; n_probe = 1; end
           else n_flush++;
         end
      1: if (prog_clk_en) n_probe++;
         else begin off_err = error; phase = 2; end
      2: if (prog_clk_en) begin
           n_load++;
           if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
           else chk("load_bit", 64'(ccff_head), 64'(sb.pop_front()));
         end else if (n_load > 0 && n_load < BS) n_bubble++;
      default: ;
    endcase
  end

  typedef struct {
    int            mode;
    int            stall;
    logic          exp_done;
    logic          exp_err;
    logic [1:0]    exp_code;
    int            exp_probe;
    int            exp_load;
    int            exp_bubble;
    logic          exp_ready;
    logic [BS-1:0] exp_chain;
  } vec_t;

  vec_t          vecs[4];
  logic [WW-1:0] words[3];
  int            wbits[3];

  task automatic run_scn(input vec_t v, input int abort_at, output bit aborted);
    int wsent, stall;
    bit fin;
    aborted   = 1'b0;
    fin       = 1'b0;
    tail_mode = v.mode;
    phase = 0; n_flush = 0; n_probe = 0; n_load = 0; n_bubble = 0;
    ready_seen = 1'b0; off_err = 1'b0;
    sb.delete();
    wsent = 0;
    stall = v.stall;
    start = 1'b1;
    @(posedge prog_clk); #2;
    start = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (done || error) begin fin = 1'b1; break; end
      if (abort_at > 0 && n_load >= abort_at) begin
        abort = 1'b1; start = 1'b1; bs_valid = 1'b0;
        @(posedge prog_clk); #2;
        abort = 1'b0; start = 1'b0;
        aborted = 1'b1; fin = 1'b1;
        break;
      end
      if (bs_ready && wsent < 3) begin
        if (wsent > 0 && stall > 0) begin
          bs_valid = 1'b0;
          stall--;
        end else begin
          bs_valid = 1'b1;
          bs_data  = words[wsent];
          for (int b = 0; b < wbits[wsent]; b++) sb.push_back(words[wsent][WW-1-b]);
          wsent++;
        end
      end else begin
        bs_valid = 1'b0;
      end
      @(posedge prog_clk); #2;
    end
    bs_valid = 1'b0;
    chk("finished_in_budget", 64'(fin), 64'd1);
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    chk($sformatf("v%0d_done", idx), 64'(done), 64'(v.exp_done));
    chk($sformatf("v%0d_error", idx), 64'(error), 64'(v.exp_err));
    chk($sformatf("v%0d_err_code", idx), 64'(err_code), 64'(v.exp_code));
    chk($sformatf("v%0d_flush_cycles", idx), 64'(n_flush), 64'(BS));
    chk($sformatf("v%0d_probe_cycles", idx), 64'(n_probe), 64'(v.exp_probe));
    chk($sformatf("v%0d_err_after_probe", idx), 64'(off_err), 64'(v.exp_err));
    chk($sformatf("v%0d_load_bits", idx), 64'(n_load), 64'(v.exp_load));
    chk($sformatf("v%0d_bubbles", idx), 64'(n_bubble), 64'(v.exp_bubble));
    chk($sformatf("v%0d_ready_seen", idx), 64'(ready_seen), 64'(v.exp_ready));
    chk($sformatf("v%0d_busy", idx), 64'(busy), 64'd0);
    chk($sformatf("v%0d_clk_en", idx), 64'(prog_clk_en), 64'd0);
    chk($sformatf("v%0d_sb_left", idx), 64'(sb.size()), 64'd0);
    if (v.exp_done) chk($sformatf("v%0d_chain", idx), 64'(chain), 64'(v.exp_chain));
  endtask

  initial begin
    bit ab;
    words[0] = 16'hA5C3; words[1] = 16'h0F0F; words[2] = 16'hF0FF;
    wbits[0] = 16;       wbits[1] = 16;       wbits[2] = 8;
    //          mode stall done err  code   probe load bub rdy  chain
    vecs[0] = '{0,   0,    1'b1, 1'b0, 2'b00, 41,   40,  0,  1'b1, 40'hA5C30F0FF0};
    vecs[1] = '{0,   6,    1'b1, 1'b0, 2'b00, 41,   40,  5,  1'b1, 40'hA5C30F0FF0};
    vecs[2] = '{1,   0,    1'b0, 1'b1, 2'b01, 38,   0,   0,  1'b0, 40'h0};
    vecs[3] = '{2,   0,    1'b0, 1'b1, 2'b10, 49,   0,   0,  1'b0, 40'h0};

    phase = 3;
    pReset = 1'b1; start = 1'b1; abort = 1'b0; bs_valid = 1'b0; bs_data = '0;
    repeat (2) @(posedge prog_clk);
    #2;
    chk("rst_head", 64'(ccff_head), 64'd0);
    chk("rst_clk_en", 64'(prog_clk_en), 64'd0);
    chk("rst_ready", 64'(bs_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    pReset = 1'b0; start = 1'b0;
    repeat (3) @(posedge prog_clk);
    #2;
    chk("post_rst_idle_busy", 64'(busy), 64'd0);
    chk("post_rst_idle_en", 64'(prog_clk_en), 64'd0);

    for (int i = 0; i < 4; i++) begin
      run_scn(vecs[i], 0, ab);
      @(negedge prog_clk); #1;
      check_vec(vecs[i], i);
    end

    // Abort with a simultaneous start in the middle of LOAD, then a fresh full load.
    run_scn(vecs[0], 20, ab);
    chk("abort_taken", 64'(ab), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_clk_en", 64'(prog_clk_en), 64'd0);
    chk("abort_ready", 64'(bs_ready), 64'd0);
    chk("abort_head", 64'(ccff_head), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_error", 64'(error), 64'd0);
    @(posedge prog_clk); #2;
    chk("abort_stays_idle", 64'(busy), 64'd0);
    run_scn(vecs[0], 0, ab);
    @(negedge prog_clk); #1;
    check_vec(vecs[0], 4);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter BS_LGT, default 8387: configuration chain length in bits.
REQ-002 SHALL have parameter WORD_W, default 32: bitstream word width.
REQ-003 SHALL have parameter PROBE_EN, default 1: 1 = run FLUSH and PROBE before LOAD; 0 = go straight to LOAD.
REQ-004 SHALL have port prog_clk  in  1  single clock, rising-edge.
REQ-005 SHALL have port pReset  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a programming sequence.
REQ-007 SHALL have port abort  in  1  cancel the current sequence.
REQ-008 SHALL have port bs_data  in  WORD_W  bitstream word; MSB is shifted first.
REQ-009 SHALL have port bs_valid  in  1  bs_data is valid.
REQ-010 SHALL have port bs_ready  out  1  loader accepts bs_data this cycle.
REQ-011 SHALL have port ccff_head  out  1  registered serial bit into the chain.
REQ-012 SHALL have port ccff_tail  in  1  serial bit out of the chain.
REQ-013 SHALL have port prog_clk_en  out  1  chain shifts on this edge; gates the fabric prog_clk.
REQ-014 SHALL have port busy  out  1  state is FLUSH, PROBE or LOAD.
REQ-015 SHALL have port done  out  1  load complete; sticky.
REQ-016 SHALL have port error  out  1  probe failed; sticky.
REQ-017 SHALL have port err_code  out  2  01 = chain short; 10 = chain long or broken; 00 = none.

Function
REQ-018 SHALL implement states IDLE, FLUSH, PROBE, LOAD, DONE, ERROR.
REQ-019 SHALL, on start in IDLE, DONE or ERROR, clear done, error and err_code and go to FLUSH (PROBE_EN=1) or LOAD (PROBE_EN=0); start SHALL be ignored in any other state.
REQ-020 FLUSH SHALL drive ccff_head=0 with prog_clk_en=1 for exactly BS_LGT cycles, then go to PROBE.
REQ-021 PROBE SHALL drive ccff_head=1 on its first cycle (probe count 0) and 0 afterwards, with prog_clk_en=1 throughout; the count increments every cycle.
REQ-022 PROBE SHALL go to LOAD when ccff_tail=1 and count==BS_LGT.
REQ-023 PROBE SHALL go to ERROR with err_code=01 when ccff_tail=1 and 0<count<BS_LGT.
REQ-024 PROBE SHALL go to ERROR with err_code=10 when count reaches BS_LGT+8 with no ccff_tail=1 seen.
REQ-025 ccff_tail SHALL be ignored at count 0.
REQ-026 LOAD SHALL need ceil(BS_LGT/WORD_W) words; bs_ready=1 when the word shift register is empty, or its last bit shifts this cycle, and words remain.
REQ-027 A word SHALL be accepted only on bs_valid & bs_ready; no word is accepted in any other state.
REQ-028 Each enabled LOAD cycle SHALL shift one bit MSB-first; prog_clk_en=1 only while a bit is available.
REQ-029 If a word is not yet available (stall), prog_clk_en SHALL be 0, ccff_head SHALL hold, and counters SHALL hold.
REQ-030 From the last word, only the top (BS_LGT - (words-1)*WORD_W) bits SHALL be shifted; the remaining low bits are discarded.
REQ-031 After exactly BS_LGT shifted bits, the loader SHALL go to DONE with done=1 and prog_clk_en=0 on the next cycle.
REQ-032 In DONE and ERROR, done, error and err_code SHALL be held until the next start or pReset.
REQ-033 The bit counter SHALL be ceil(log2(BS_LGT+9)) bits wide and SHALL never wrap.
REQ-034 abort in any state SHALL return to IDLE on the next edge with prog_clk_en=0, bs_ready=0, ccff_head=0, done=0, error=0 and err_code=00.
REQ-035 abort SHALL take priority over a simultaneous start.
REQ-036 busy SHALL be combinational from the state; all other outputs SHALL be registered except bs_ready.

Reset
REQ-037 pReset SHALL force IDLE and ccff_head=0, prog_clk_en=0, bs_ready=0, busy=0, done=0, error=0, err_code=00, and clear all counters.
REQ-038 pReset mid-sequence SHALL behave as abort and SHALL take priority over start and abort.

Verification (BS_LGT=40, WORD_W=16, 40-bit shift-register chain model clocked on prog_clk & prog_clk_en)
REQ-039 Reset: pReset high 2 cycles -> all outputs 0 and IDLE; start held during reset is ignored.
REQ-040 Clean load: PROBE_EN=1, words 0xA5C3, 0x0F0F, 0xF0FF -> 40 FLUSH cycles, probe tail seen at count 40, 40 LOAD bits, chain model = 0xA5C30F0FF0, done=1, error=0.
REQ-041 Stall: bs_valid low for 5 cycles after the first word -> prog_clk_en=0 for those 5 cycles, chain unchanged, final contents identical to REQ-040.
REQ-042 Short chain: 37-bit model -> error=1, err_code=01, no bs_ready ever asserted.
REQ-043 Broken chain: ccff_tail stuck 0 -> error=1, err_code=10 on the cycle after count reaches 48.
REQ-044 Abort: abort asserted after 20 LOAD bits, start in the same cycle -> IDLE next cycle, prog_clk_en=0, done=0; a fresh start then completes a full load correctly.
